// File: rtl/axil_sram_slave.sv
// AXI4-Lite responder in front of a word-organised SRAM model.
// Independent read and write FSMs, each returning its response a programmable number of cycles after acceptance.
module axil_sram_slave #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h8000_0000,
  parameter int unsigned       MEM_DEPTH = 4096,
  parameter int unsigned       LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);
  localparam int unsigned       IDX_W       = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] SPAN        = ADDR_W'(32'd4 * MEM_DEPTH);
  localparam logic [7:0]        LAT         = 8'(LATENCY);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rstate_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wstate_e;

  function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
    return (a >= MEM_BASE) && ((a - MEM_BASE) < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - MEM_BASE) >> 2);
  endfunction

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  rstate_e           rstate_q;
  logic [7:0]        rcnt_q;
  logic [ADDR_W-1:0] raddr_q;
  wstate_e           wstate_q;
  logic [7:0]        wcnt_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;

  logic [ADDR_W-1:0] rd_addr_s;
  logic              rd_hit_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic              wr_hit_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic              wr_commit_s;
  logic              aw_done_s;
  logic              w_done_s;

  // With zero latency the array is read straight from araddr in the accept cycle.
  always_comb begin
    rd_addr_s   = (rstate_q == R_IDLE) ? araddr : raddr_q;
    rd_hit_s    = addr_hit(rd_addr_s);
    rd_idx_s    = word_idx(rd_addr_s);
    wr_hit_s    = addr_hit(awaddr_q);
    wr_idx_s    = word_idx(awaddr_q);
    wr_commit_s = (wstate_q == W_WAIT) && (wcnt_q <= 8'd1);
    aw_done_s   = !awready || awvalid;
    w_done_s    = !wready || wvalid;
  end

  // Read channel FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q <= R_IDLE;
      rcnt_q   <= 8'd0;
      raddr_q  <= {ADDR_W{1'b0}};
      arready  <= 1'b1;
      rvalid   <= 1'b0;
      rdata    <= {DATA_W{1'b0}};
      rresp    <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (arvalid) begin
            raddr_q <= araddr;
            arready <= 1'b0;
            if (LAT == 8'd0) begin
              rdata    <= rd_hit_s ? mem_q[rd_idx_s] : {DATA_W{1'b0}};
              rresp    <= rd_hit_s ? RESP_OKAY : RESP_SLVERR;
              rvalid   <= 1'b1;
              rstate_q <= R_RESP;
            end else begin
              rcnt_q   <= LAT;
              rstate_q <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (rcnt_q <= 8'd1) begin
            rcnt_q   <= 8'd0;
            rdata    <= rd_hit_s ? mem_q[rd_idx_s] : {DATA_W{1'b0}};
            rresp    <= rd_hit_s ? RESP_OKAY : RESP_SLVERR;
            rvalid   <= 1'b1;
            rstate_q <= R_RESP;
          end else begin
            rcnt_q <= rcnt_q - 8'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid   <= 1'b0;
            arready  <= 1'b1;
            rstate_q <= R_IDLE;
          end
        end
        default: begin
          rstate_q <= R_IDLE;
          arready  <= 1'b1;
          rvalid   <= 1'b0;
        end
      endcase
    end
  end

  // Write channel FSM; AW and W are captured independently before the latency count starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q <= W_IDLE;
      wcnt_q   <= 8'd0;
      awaddr_q <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      wstrb_q  <= 4'd0;
      awready  <= 1'b1;
      wready   <= 1'b1;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (awready && awvalid) begin
            awaddr_q <= awaddr;
            awready  <= 1'b0;
          end
          if (wready && wvalid) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            wready  <= 1'b0;
          end
          if (aw_done_s && w_done_s) begin
            awready  <= 1'b0;
            wready   <= 1'b0;
            wcnt_q   <= LAT;
            wstate_q <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (wr_commit_s) begin
            wcnt_q   <= 8'd0;
            bvalid   <= 1'b1;
            bresp    <= wr_hit_s ? RESP_OKAY : RESP_SLVERR;
            wstate_q <= W_RESP;
          end else begin
            wcnt_q <= wcnt_q - 8'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
            wstate_q <= W_IDLE;
          end
        end
        default: begin
          wstate_q <= W_IDLE;
          awready  <= 1'b1;
          wready   <= 1'b1;
          bvalid   <= 1'b0;
        end
      endcase
    end
  end

  // SRAM array: strobed byte-lane writes at commit; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_commit_s && wr_hit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem_q[wr_idx_s][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Bench for axil_sram_slave: one instance at LATENCY=1 and one at LATENCY=0, sharing a
// single set of bus drivers with valids steered by sel0; responses checked via scoreboard queues.
module tb_axil_sram_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel0;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        arvalid, rready, awvalid, wvalid, bready;

  logic        arready1, rvalid1, awready1, wready1, bvalid1;
  logic [31:0] rdata1;
  logic [1:0]  rresp1, bresp1;
  logic        arready0, rvalid0, awready0, wready0, bvalid0;
  logic [31:0] rdata0;
  logic [1:0]  rresp0, bresp0;

  logic        arready_m, rvalid_m, awready_m, wready_m, bvalid_m;
  logic [31:0] rdata_m;
  logic [1:0]  rresp_m, bresp_m;
  assign arready_m = sel0 ? arready0 : arready1;
  assign rvalid_m  = sel0 ? rvalid0  : rvalid1;
  assign awready_m = sel0 ? awready0 : awready1;
  assign wready_m  = sel0 ? wready0  : wready1;
  assign bvalid_m  = sel0 ? bvalid0  : bvalid1;
  assign rdata_m   = sel0 ? rdata0   : rdata1;
  assign rresp_m   = sel0 ? rresp0   : rresp1;
  assign bresp_m   = sel0 ? bresp0   : bresp1;

  axil_sram_slave #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arvalid(arvalid & ~sel0), .arready(arready1),
    .rdata(rdata1), .rresp(rresp1), .rvalid(rvalid1), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid & ~sel0), .awready(awready1),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid & ~sel0), .wready(wready1),
    .bresp(bresp1), .bvalid(bvalid1), .bready(bready)
  );

  axil_sram_slave #(.LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arvalid(arvalid & sel0), .arready(arready0),
    .rdata(rdata0), .rresp(rresp0), .rvalid(rvalid0), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid & sel0), .awready(awready0),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid & sel0), .wready(wready0),
    .bresp(bresp0), .bvalid(bvalid0), .bready(bready)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;
  rexp_t      r_q[$];
  logic [1:0] b_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp_resp, input int exp_lat);
    int n;
    int lat;
    logic [1:0] e;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready_m && wready_m) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wr_accept", 32'(n < 50), 32'd1);
    b_q.push_back(exp_resp);
    lat = 0;
    do begin
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      lat++;
    end while (!bvalid_m && lat < 50);
    check("wr_latency", 32'(lat), 32'(exp_lat));
    e = b_q.pop_front();
    check("bresp", {30'd0, bresp_m}, {30'd0, e});
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int exp_lat);
    int n;
    int lat;
    rexp_t e;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rd_accept", 32'(n < 50), 32'd1);
    r_q.push_back('{data: exp_data, resp: exp_resp});
    lat = 0;
    do begin
      @(negedge clk);
      arvalid = 1'b0;
      lat++;
    end while (!rvalid_m && lat < 50);
    check("rd_latency", 32'(lat), 32'(exp_lat));
    e = r_q.pop_front();
    check("rdata", rdata_m, e.data);
    check("rresp", {30'd0, rresp_m}, {30'd0, e.resp});
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;
  vec_t vecs[10];

  initial begin
    rexp_t re;
    logic [1:0] be;
    vecs[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 2'b00, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'b1111, 2'b00, 32'h1122_3344, 2'b00};
    vecs[2] = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2'b00, 32'h11BB_33DD, 2'b00};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h5555_AAAA, 4'b1111, 2'b00, 32'h5555_AAAA, 2'b00};
    vecs[4] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'b0000, 2'b00, 32'h0,         2'b10};
    vecs[5] = '{1'b1, 32'h8000_4000, 32'h9999_9999, 4'b1111, 2'b10, 32'h0,         2'b10};
    vecs[6] = '{1'b0, 32'h8000_0000, 32'h0,         4'b0000, 2'b00, 32'h5555_AAAA, 2'b00};
    vecs[7] = '{1'b1, 32'h8000_3FFE, 32'h0BAD_F00D, 4'b1111, 2'b00, 32'h0BAD_F00D, 2'b00};
    vecs[8] = '{1'b1, 32'h8000_0012, 32'h7700_0000, 4'b1000, 2'b00, 32'h77AD_BEEF, 2'b00};
    vecs[9] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 2'b00, 32'h0,         2'b10};

    rst_n = 1'b0; sel0 = 1'b0;
    araddr = 32'd0; awaddr = 32'd0; wdata = 32'd0; wstrb = 4'd0;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b1; bready = 1'b1;

    // reset values while rst_n is held low
    #12;
    check("rst_arready", {31'd0, arready1}, 32'd1);
    check("rst_awready", {31'd0, awready1}, 32'd1);
    check("rst_wready",  {31'd0, wready1},  32'd1);
    check("rst_rvalid",  {31'd0, rvalid1},  32'd0);
    check("rst_bvalid",  {31'd0, bvalid1},  32'd0);
    check("rst_rdata",   rdata1,            32'd0);
    check("rst_rresp",   {30'd0, rresp1},   32'd0);
    check("rst_bresp",   {30'd0, bresp1},   32'd0);
    check("rst_l0_ready", {29'd0, arready0, awready0, wready0}, 32'd7);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].bresp, 2);
      end
      axi_read(vecs[i].addr, vecs[i].rdata, vecs[i].rresp, 2);
    end

    // decoupled AW then W three cycles later, response stalled by bready=0
    axi_write(32'h8000_0040, 32'h0102_0304, 4'b1111, 2'b00, 2);
    @(negedge clk);
    awaddr = 32'h8000_0040; wdata = 32'hA5A5_5A5A; wstrb = 4'b1111;
    awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    b_q.push_back(2'b00);
    @(negedge clk);
    awvalid = 1'b0;
    check("dec_awready_c1", {31'd0, awready_m}, 32'd0);
    check("dec_wready_c1",  {31'd0, wready_m},  32'd1);
    @(negedge clk);
    check("dec_wready_c2",  {31'd0, wready_m},  32'd1);
    check("dec_bvalid_c2",  {31'd0, bvalid_m},  32'd0);
    @(negedge clk);
    check("dec_wready_c3",  {31'd0, wready_m},  32'd1);
    wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("dec_wready_c4",  {31'd0, wready_m},  32'd0);
    check("dec_bvalid_c4",  {31'd0, bvalid_m},  32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("dec_bvalid_hold", {31'd0, bvalid_m}, 32'd1);
    end
    be = b_q.pop_front();
    check("dec_bresp", {30'd0, bresp_m}, {30'd0, be});
    bready = 1'b1;
    @(negedge clk);
    check("dec_bvalid_done", {31'd0, bvalid_m}, 32'd0);
    check("dec_ready_back", {30'd0, awready_m, wready_m}, 32'd3);
    axi_read(32'h8000_0040, 32'hA5A5_5A5A, 2'b00, 2);

    // LATENCY=0: read load and write commit on the same edge
    sel0 = 1'b1;
    axi_write(32'h8000_0080, 32'h0102_0304, 4'b1111, 2'b00, 2);
    axi_read(32'h8000_0080, 32'h0102_0304, 2'b00, 1);
    @(negedge clk);
    awaddr = 32'h8000_0080; wdata = 32'hCAFE_F00D; wstrb = 4'b1111;
    awvalid = 1'b1; wvalid = 1'b1;
    b_q.push_back(2'b00);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h8000_0080; arvalid = 1'b1;
    check("col_arready", {31'd0, arready_m}, 32'd1);
    r_q.push_back('{data: 32'h0102_0304, resp: 2'b00});
    @(negedge clk);
    arvalid = 1'b0;
    check("col_rvalid", {31'd0, rvalid_m}, 32'd1);
    check("col_bvalid", {31'd0, bvalid_m}, 32'd1);
    re = r_q.pop_front();
    check("col_rdata_old", rdata_m, re.data);
    be = b_q.pop_front();
    check("col_bresp", {30'd0, bresp_m}, {30'd0, be});
    axi_read(32'h8000_0080, 32'hCAFE_F00D, 2'b00, 1);

    // reset during W_WAIT abandons the write
    sel0 = 1'b0;
    axi_write(32'h8000_00C0, 32'h1234_5678, 4'b1111, 2'b00, 2);
    @(negedge clk);
    awaddr = 32'h8000_00C0; wdata = 32'hFFFF_FFFF; wstrb = 4'b1111;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("mr_in_wait", {30'd0, awready_m, wready_m}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mr_bvalid", {31'd0, bvalid_m}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_readies", {29'd0, arready_m, awready_m, wready_m}, 32'd7);
    axi_read(32'h8000_00C0, 32'h1234_5678, 2'b00, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
